// File: rtl/aes_state_loader.sv
// Packs four 32-bit column words into a 4x4 AES state and hands it off over valid/ready.
// Optional macro AES_LOADER_KEYXOR_EN adds key_in and XORs it into each captured byte.
module aes_state_loader #(
  parameter bit BYTE_MSB_FIRST = 1'b1,
  parameter int CNT_W          = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   abort,
  input  logic [31:0]            word_in,
  input  logic                   word_valid,
  output logic                   word_ready,
`ifdef AES_LOADER_KEYXOR_EN
  input  logic [0:3][0:3][7:0]   key_in,
`endif
  output logic [0:3][0:3][7:0]   state_out,
  output logic                   state_valid,
  input  logic                   state_ready,
  output logic [CNT_W-1:0]       block_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } fsm_e;

  fsm_e                  state_q, state_d;
  logic [1:0]            col_cnt_q, col_cnt_d;
  logic [0:3][0:3][7:0]  data_q, data_d;
  logic                  valid_q, valid_d;
  logic [CNT_W-1:0]      blk_q, blk_d;

  logic [0:3][7:0]       col_bytes;
  logic                  word_xfer;
  logic                  handoff;

  // A held block can only make room for a new word in the same cycle it is consumed.
  always_comb begin
    if (state_q == FILL) begin
      word_ready = ~abort;
    end else begin
      word_ready = state_ready & ~abort;
    end
  end

  assign word_xfer = word_valid & word_ready;
  assign handoff   = valid_q & state_ready & ~abort;

  always_comb begin
    col_bytes = '0;
    for (int r = 0; r < 4; r++) begin
      if (BYTE_MSB_FIRST) begin
        col_bytes[r] = word_in[(31 - 8*r) -: 8];
      end else begin
        col_bytes[r] = word_in[(8*r) +: 8];
      end
`ifdef AES_LOADER_KEYXOR_EN
      col_bytes[r] = col_bytes[r] ^ key_in[r][col_cnt_q];
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_cnt_d = col_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    blk_d     = blk_q;

    if (abort) begin
      state_d   = FILL;
      col_cnt_d = 2'd0;
      valid_d   = 1'b0;
      data_d    = '0;
    end else begin
      if (handoff) begin
        blk_d     = blk_q + CNT_W'(1);
        state_d   = FILL;
        valid_d   = 1'b0;
        col_cnt_d = 2'd0;
      end
      // In HOLD a word can only arrive alongside a handoff, and col_cnt_q is 0 there.
      if (word_xfer) begin
        for (int r = 0; r < 4; r++) begin
          data_d[r][col_cnt_q] = col_bytes[r];
        end
        col_cnt_d = col_cnt_q + 2'd1;
        if ((state_q == FILL) && (col_cnt_q == 2'd3)) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      col_cnt_q <= 2'd0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      blk_q     <= '0;
    end else begin
      state_q   <= state_d;
      col_cnt_q <= col_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      blk_q     <= blk_d;
    end
  end

  assign state_out   = data_q;
  assign state_valid = valid_q;
  assign block_cnt   = blk_q;

endmodule

// File: tb/tb_aes_state_loader.sv
// Self-checking bench for aes_state_loader: directed scenarios followed by a randomized
// handshake run, all compared against a word-queue reference model.
module tb_aes_state_loader;

  localparam int CNT_W = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  abort = 1'b0;
  logic [31:0]           word_in = '0;
  logic                  word_valid = 1'b0;
  logic                  word_ready;
  logic [0:3][0:3][7:0]  state_out;
  logic                  state_valid;
  logic                  state_ready = 1'b0;
  logic [CNT_W-1:0]      block_cnt;
`ifdef AES_LOADER_KEYXOR_EN
  logic [0:3][0:3][7:0]  key_in;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: words of the current block, the expected byte grid, held flag, count.
  logic [31:0] m_words[$];
  logic [7:0]  m_st[4][4];
  bit          m_held;
  int          m_cnt;

  aes_state_loader #(
    .BYTE_MSB_FIRST(1'b1),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .word_in(word_in),
    .word_valid(word_valid),
    .word_ready(word_ready),
`ifdef AES_LOADER_KEYXOR_EN
    .key_in(key_in),
`endif
    .state_out(state_out),
    .state_valid(state_valid),
    .state_ready(state_ready),
    .block_cnt(block_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] keyByte(int r, int c);
`ifdef AES_LOADER_KEYXOR_EN
    return 8'(r + 4*c);
`else
    return 8'(0 * (r + c));
`endif
  endfunction

  function automatic logic modelReady(logic ab, logic sr);
    return !ab && (!m_held || sr);
  endfunction

  function automatic logic [0:3][0:3][7:0] expState();
    logic [0:3][0:3][7:0] s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = m_st[r][c];
    return s;
  endfunction

  task automatic modelReset();
    m_words.delete();
    m_held = 1'b0;
    m_cnt  = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m_st[r][c] = 8'h00;
  endtask

  task automatic modelStep(input logic ab, input logic xfer, input logic [31:0] w, input logic sr);
    int col;
    if (ab) begin
      m_words.delete();
      m_held = 1'b0;
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          m_st[r][c] = 8'h00;
    end else begin
      if (m_held && sr) begin
        m_cnt  = (m_cnt + 1) % (1 << CNT_W);
        m_held = 1'b0;
        m_words.delete();
      end
      if (xfer) begin
        col = m_words.size();
        for (int r = 0; r < 4; r++)
          m_st[r][col] = 8'((w >> (24 - 8*r)) & 32'hFF) ^ keyByte(r, col);
        m_words.push_back(w);
        if (m_words.size() == 4) m_held = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".state_valid"}, 128'(state_valid), 128'(m_held));
    checkOutput({tag, ".state_out"}, 128'(state_out), 128'(expState()));
    checkOutput({tag, ".block_cnt"}, 128'(block_cnt), 128'(m_cnt));
  endtask

  // One clock cycle: drive at the falling edge, check ready before the rising edge,
  // advance the model at the rising edge, check registered outputs at the next falling edge.
  task automatic applyStimulus(input string tag, input logic ab, input logic wv,
                               input logic [31:0] w, input logic sr);
    logic rdy;
    abort       = ab;
    word_valid  = wv;
    word_in     = w;
    state_ready = sr;
    #1;
    rdy = modelReady(ab, sr);
    checkOutput({tag, ".word_ready"}, 128'(word_ready), 128'(rdy));
    @(posedge clk);
    modelStep(ab, wv && rdy, w, sr);
    @(negedge clk);
    abort       = 1'b0;
    word_valid  = 1'b0;
    state_ready = 1'b0;
    checkAll(tag);
  endtask

  task automatic fillWords(input string tag, input int n);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b1, $urandom, 1'b0);
  endtask

  initial begin
`ifdef AES_LOADER_KEYXOR_EN
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        key_in[r][c] = 8'(r + 4*c);
`endif
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkAll("reset");
    checkOutput("reset.word_ready", 128'(word_ready), 128'(1));
    @(negedge clk);

    // Scenario 1: four back-to-back words with downstream stalled.
    applyStimulus("s1.w0", 1'b0, 1'b1, 32'h00112233, 1'b0);
    applyStimulus("s1.w1", 1'b0, 1'b1, 32'h44556677, 1'b0);
    applyStimulus("s1.w2", 1'b0, 1'b1, 32'h8899AABB, 1'b0);
    applyStimulus("s1.w3", 1'b0, 1'b1, 32'hCCDDEEFF, 1'b0);
    checkOutput("s1.valid", 128'(state_valid), 128'(1));
    checkOutput("s1.r0c0", 128'(state_out[0][0]), 128'(8'h00 ^ keyByte(0, 0)));
    checkOutput("s1.r1c0", 128'(state_out[1][0]), 128'(8'h11 ^ keyByte(1, 0)));
    checkOutput("s1.r0c1", 128'(state_out[0][1]), 128'(8'h44 ^ keyByte(0, 1)));
    checkOutput("s1.r3c3", 128'(state_out[3][3]), 128'(8'hFF ^ keyByte(3, 3)));
    applyStimulus("s1.held", 1'b0, 1'b1, 32'hDEADBEEF, 1'b0);

    // Scenario 2: handoff with a simultaneous first word of the next block.
    applyStimulus("s2.hand", 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    checkOutput("s2.cnt", 128'(block_cnt), 128'(1));
    checkOutput("s2.valid", 128'(state_valid), 128'(0));
    checkOutput("s2.r0c0", 128'(state_out[0][0]), 128'(8'hDE ^ keyByte(0, 0)));
    fillWords("s2.fill", 3);
    checkOutput("s2.valid2", 128'(state_valid), 128'(1));

    // Scenario 3: handoff without a word, then abort part-way through a block.
    applyStimulus("s3.hand", 1'b0, 1'b0, 32'h0, 1'b1);
    fillWords("s3.fill", 2);
    applyStimulus("s3.abort", 1'b1, 1'b1, 32'h12345678, 1'b0);
    checkOutput("s3.cleared", 128'(state_out), 128'(0));
    fillWords("s3.refill", 4);
    applyStimulus("s3.hand2", 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s3.cnt3", 128'(block_cnt), 128'(3));
    fillWords("s4.fill", 4);
    applyStimulus("s4.hand", 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s4.cnt_wrap", 128'(block_cnt), 128'(0));
    fillWords("s4.fill2", 4);
    applyStimulus("s4.hand2", 1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("s4.cnt1", 128'(block_cnt), 128'(1));

    // Abort while a held block is being consumed: no handoff is counted.
    fillWords("s5.fill", 4);
    applyStimulus("s5.abort_hold", 1'b1, 1'b1, 32'hCAFEF00D, 1'b1);
    checkOutput("s5.cnt_kept", 128'(block_cnt), 128'(1));

    // Asynchronous reset in the middle of a block, away from any clock edge.
    fillWords("s6.fill", 2);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("s6.async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("s6.word_ready", 128'(word_ready), 128'(1));
    @(negedge clk);

    // Randomized handshake traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand", ($urandom % 16) == 0, ($urandom % 4) != 0, $urandom,
                    ($urandom % 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
